tile_frame_assembler: RTL and testbench

Sits directly upstream of the VGA frame-buffer writer. It sequences the shader core (SM) through every 16x16 tile of a 640x480 frame in raster order. For each tile it accepts 16 rows of 8-bit color, packs them into the 2048-bit tile word in the exact byte order the frame-buffer write port expects, then emits a one-cycle commit strobe with the tile coordinates. One frame is 40x30 = 1200 tiles.

---
 rtl/tile_frame_assembler.sv | 150 +++++++++++++++
 tb/tb_tile_frame_assembler.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_frame_assembler.sv
// Tile frame assembler.
// Walks the shader core through every tile of a frame in raster order,
// collects sixteen 128-bit pixel rows per tile into one 2048-bit word laid
// out for the frame-buffer write port, and strobes a commit with the tile
// coordinates once the last row has arrived.
//
// Row handshake: a row transfers on a rising clock edge where both
// i_row_valid and o_row_ready are high. o_row_ready is high only while
// collecting, so rows offered at any other time stay with the producer.
//
// TILES_X / TILES_Y must lie in 1..64 so the coordinates fit in 6 bits.
module tile_frame_assembler #(
    parameter int TILES_X = 40,
    parameter int TILES_Y = 30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_frame_start,
    output logic          o_busy,
    output logic          o_tile_start,
    output logic [5:0]    o_dispatch_tile_x,
    output logic [5:0]    o_dispatch_tile_y,
    input  logic          i_row_valid,
    output logic          o_row_ready,
    input  logic [127:0]  i_row_data,
    output logic          o_sm_render_done,
    output logic [5:0]    o_current_tile_x,
    output logic [5:0]    o_current_tile_y,
    output logic [2047:0] o_sm_color_data,
    output logic          o_frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_COLLECT  = 2'd2,
        ST_COMMIT   = 2'd3
    } state_t;

    localparam logic [5:0] LAST_X = 6'(TILES_X - 1);
    localparam logic [5:0] LAST_Y = 6'(TILES_Y - 1);

    state_t      state;
    logic [5:0]  tile_x;
    logic [5:0]  tile_y;
    logic [3:0]  row_cnt;

    logic        row_accept;
    logic        last_col;
    logic        last_tile;
    logic [3:0]  row_slot;
    logic [10:0] row_base;

    // Handshake, raster-position flags and the buffer slot for the incoming row.
    // Row 0 lands in the most significant 128 bits so pixel (0,0) ends up in
    // the top byte and pixel (15,15) in the bottom byte of the tile word.
    always_comb begin
        row_accept = i_row_valid && o_row_ready;
        last_col   = (tile_x == LAST_X);
        last_tile  = last_col && (tile_y == LAST_Y);
        row_slot   = 4'd15 - row_cnt;
        row_base   = {row_slot, 7'd0};
    end

    // The dispatch coordinates are the live tile counters.
    assign o_dispatch_tile_x = tile_x;
    assign o_dispatch_tile_y = tile_y;

    // Frame sequencer: state, counters, tile buffer and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            tile_x           <= 6'd0;
            tile_y           <= 6'd0;
            row_cnt          <= 4'd0;
            o_busy           <= 1'b0;
            o_tile_start     <= 1'b0;
            o_row_ready      <= 1'b0;
            o_sm_render_done <= 1'b0;
            o_frame_done     <= 1'b0;
            o_current_tile_x <= 6'd0;
            o_current_tile_y <= 6'd0;
            o_sm_color_data  <= '0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            o_tile_start     <= 1'b0;
            o_sm_render_done <= 1'b0;
            o_frame_done     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_frame_start) begin
                        state        <= ST_DISPATCH;
                        tile_x       <= 6'd0;
                        tile_y       <= 6'd0;
                        o_busy       <= 1'b1;
                        o_tile_start <= 1'b1;
                    end
                end

                ST_DISPATCH: begin
                    state       <= ST_COLLECT;
                    row_cnt     <= 4'd0;
                    o_row_ready <= 1'b1;
                end

                ST_COLLECT: begin
                    if (row_accept) begin
                        o_sm_color_data[row_base +: 128] <= i_row_data;
                        row_cnt <= row_cnt + 4'd1;
                        if (row_cnt == 4'd15) begin
                            // Last row: commit this tile on the next cycle.
                            state            <= ST_COMMIT;
                            o_row_ready      <= 1'b0;
                            o_sm_render_done <= 1'b1;
                            o_frame_done     <= last_tile;
                            o_current_tile_x <= tile_x;
                            o_current_tile_y <= tile_y;
                        end
                    end
                end

                ST_COMMIT: begin
                    if (last_tile) begin
                        state  <= ST_IDLE;
                        tile_x <= 6'd0;
                        tile_y <= 6'd0;
                        o_busy <= 1'b0;
                    end else begin
                        state        <= ST_DISPATCH;
                        o_tile_start <= 1'b1;
                        if (last_col) begin
                            tile_x <= 6'd0;
                            tile_y <= tile_y + 6'd1;
                        end else begin
                            tile_x <= tile_x + 6'd1;
                        end
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    o_busy      <= 1'b0;
                    o_row_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_frame_assembler.sv
// Bench for tile_frame_assembler.
// A 1x1-tile instance exercises row packing, latency and backpressure; a
// default 40x30 instance runs full frames, mid-tile reset and an ignored
// frame start. Commit coordinates are scored against a raster model.
module tb_tile_frame_assembler;

    logic clk;
    logic reset;

    // 1x1 instance
    logic          s_start, s_valid;
    logic [127:0]  s_data;
    logic          s_busy, s_tile_start, s_ready, s_done, s_frame_done;
    logic [5:0]    s_dx, s_dy, s_cx, s_cy;
    logic [2047:0] s_color;

    // default 40x30 instance
    logic          d_start, d_valid;
    logic [127:0]  d_data;
    logic          d_busy, d_tile_start, d_ready, d_done, d_frame_done;
    logic [5:0]    d_dx, d_dy, d_cx, d_cy;
    logic [2047:0] d_color;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int d_ts_cnt = 0;
    int d_rd_cnt = 0;
    int d_fd_cnt = 0;

    logic [5:0]  mx = 6'd0;
    logic [5:0]  my = 6'd0;
    logic [11:0] exp_q[$];

    logic [2047:0] exp_tile;

    tile_frame_assembler #(.TILES_X(1), .TILES_Y(1)) dut_small (
        .clk               (clk),
        .reset             (reset),
        .i_frame_start     (s_start),
        .o_busy            (s_busy),
        .o_tile_start      (s_tile_start),
        .o_dispatch_tile_x (s_dx),
        .o_dispatch_tile_y (s_dy),
        .i_row_valid       (s_valid),
        .o_row_ready       (s_ready),
        .i_row_data        (s_data),
        .o_sm_render_done  (s_done),
        .o_current_tile_x  (s_cx),
        .o_current_tile_y  (s_cy),
        .o_sm_color_data   (s_color),
        .o_frame_done      (s_frame_done)
    );

    tile_frame_assembler dut (
        .clk               (clk),
        .reset             (reset),
        .i_frame_start     (d_start),
        .o_busy            (d_busy),
        .o_tile_start      (d_tile_start),
        .o_dispatch_tile_x (d_dx),
        .o_dispatch_tile_y (d_dy),
        .i_row_valid       (d_valid),
        .o_row_ready       (d_ready),
        .i_row_data        (d_data),
        .o_sm_render_done  (d_done),
        .o_current_tile_x  (d_cx),
        .o_current_tile_y  (d_cy),
        .o_sm_color_data   (d_color),
        .o_frame_done      (d_frame_done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [127:0] row_word(input int r);
        logic [127:0] w;
        w = '0;
        for (int x = 0; x < 16; x++) w[(15 - x) * 8 +: 8] = 8'(16 * r + x);
        return w;
    endfunction

    task automatic check_tile_data(input string tag);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_w%0d", tag, i), s_color[i * 64 +: 64], exp_tile[i * 64 +: 64]);
    endtask

    // ---------------- scoreboard for the 40x30 instance ----------------
    always @(negedge clk) begin
        logic [11:0] e;
        if (d_tile_start) begin
            d_ts_cnt++;
            check("dispatch_xy", 64'({d_dy, d_dx}), 64'({my, mx}));
            check("ready_in_dispatch", 64'(d_ready), 64'd0);
            exp_q.push_back({my, mx});
            if (mx == 6'd39 && my == 6'd29) begin
                mx = 6'd0;
                my = 6'd0;
            end else if (mx == 6'd39) begin
                mx = 6'd0;
                my = my + 6'd1;
            end else begin
                mx = mx + 6'd1;
            end
        end
        if (d_done) begin
            d_rd_cnt++;
            check("commit_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("commit_xy", 64'({d_cy, d_cx}), 64'(e));
                check("frame_done_at_last", 64'(d_frame_done), 64'(e == {6'd29, 6'd39}));
            end
        end
        if (d_frame_done) d_fd_cnt++;
        if (reset) begin
            exp_q.delete();
            mx = 6'd0;
            my = 6'd0;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_row(input int r, input int gap);
        int k;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_data  = row_word(r);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_ready) break;
        end
        check("row_ready_wait", 64'(k < 50), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic small_frame(input int gapmax, input bit hold);
        int c0;
        int g;
        c0 = cyc;
        s_start = 1'b1;
        if (hold) begin
            s_valid = 1'b1;
            s_data  = row_word(0);
        end
        @(posedge clk);
        #1;
        s_start = 1'b0;
        @(negedge clk);
        check("s_tile_start", 64'(s_tile_start), 64'd1);
        check("s_tile_start_cycle", 64'(cyc - c0), 64'd1);
        check("s_ready_dispatch", 64'(s_ready), 64'd0);
        check("s_busy_dispatch", 64'(s_busy), 64'd1);
        for (int r = 0; r < 16; r++) begin
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            send_row(r, g);
        end
        if (hold) begin
            s_valid = 1'b1;
            s_data  = {8{16'hDEAD}};
        end else begin
            s_valid = 1'b0;
        end
        @(negedge clk);
        check("s_render_done", 64'(s_done), 64'd1);
        if (gapmax == 0) check("s_commit_cycle", 64'(cyc - c0), 64'd18);
        check("s_frame_done", 64'(s_frame_done), 64'd1);
        check("s_ready_commit", 64'(s_ready), 64'd0);
        check("s_busy_commit", 64'(s_busy), 64'd1);
        check("s_current_xy", 64'({s_cy, s_cx}), 64'd0);
        check("s_byte_0_0", 64'(s_color[2047:2040]), 64'h00);
        check("s_byte_1_0", 64'(s_color[2039:2032]), 64'h01);
        check("s_byte_15_15", 64'(s_color[7:0]), 64'hFF);
        check_tile_data("s_commit_data");
        @(negedge clk);
        check("s_busy_after", 64'(s_busy), 64'd0);
        check("s_done_after", 64'(s_done), 64'd0);
        check("s_frame_done_after", 64'(s_frame_done), 64'd0);
        check("s_ready_idle", 64'(s_ready), 64'd0);
        check_tile_data("s_idle_data");
        s_valid = 1'b0;
    endtask

    task automatic wait_tile(input logic [5:0] x, input logic [5:0] y, input string tag);
        int k;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (d_tile_start && d_dx == x && d_dy == y) break;
        end
        check(tag, 64'(k < 5000), 64'd1);
    endtask

    task automatic wait_frame_done(input string tag);
        int k;
        for (k = 0; k < 25000; k++) begin
            @(negedge clk);
            if (d_frame_done) break;
        end
        check(tag, 64'(k < 25000), 64'd1);
    endtask

    task automatic clear_counts();
        d_ts_cnt = 0;
        d_rd_cnt = 0;
        d_fd_cnt = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int c0;
        int act;

        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                exp_tile[(255 - (16 * y + x)) * 8 +: 8] = 8'(16 * y + x);

        reset   = 1'b1;
        s_start = 1'b0; s_valid = 1'b0; s_data = '0;
        d_start = 1'b0; d_valid = 1'b0; d_data = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(d_busy), 64'd0);
        check("rst_ready", 64'(d_ready), 64'd0);
        check("rst_tile_start", 64'(d_tile_start), 64'd0);
        check("rst_render_done", 64'(d_done), 64'd0);
        check("rst_frame_done", 64'(d_frame_done), 64'd0);
        check("rst_dispatch_xy", 64'({d_dy, d_dx}), 64'd0);
        check("rst_current_xy", 64'({d_cy, d_cx}), 64'd0);
        check("rst_color_zero", 64'(|d_color), 64'd0);
        check("rst_s_busy", 64'(s_busy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        act = 0;
        repeat (10) begin
            @(negedge clk);
            act += int'(d_busy | d_ready | d_tile_start | d_done | d_frame_done);
            act += int'(s_busy | s_ready | s_tile_start | s_done | s_frame_done);
        end
        check("idle_no_activity", 64'(act), 64'd0);
        @(posedge clk);
        #1;

        // Single-tile packing, back-to-back rows
        small_frame(0, 1'b0);

        // Reset clears the buffer so the next run must rebuild it
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("s_color_after_reset", 64'(|s_color), 64'd0);
        check("s_current_after_reset", 64'({s_cy, s_cx}), 64'd0);
        @(posedge clk);
        #1;

        // Gaps and rows offered in DISPATCH/COMMIT
        small_frame(5, 1'b1);

        // Full default frame
        d_valid = 1'b1;
        d_data  = 128'h00112233445566778899AABBCCDDEEFF;
        @(posedge clk);
        #1;
        clear_counts();
        c0 = cyc;
        d_start = 1'b1;
        @(posedge clk);
        #1;
        d_start = 1'b0;
        wait_frame_done("frame_a_done_wait");
        check("frame_a_cycles", 64'(cyc - c0), 64'd21600);
        @(posedge clk);
        #1;
        check("frame_a_commits", 64'(d_rd_cnt), 64'd1200);
        check("frame_a_tile_starts", 64'(d_ts_cnt), 64'd1200);
        check("frame_a_frame_dones", 64'(d_fd_cnt), 64'd1);
        check("frame_a_busy_after", 64'(d_busy), 64'd0);

        // Reset in the middle of tile (5,2) after its row 7
        clear_counts();
        d_start = 1'b1;
        @(posedge clk);
        #1;
        d_start = 1'b0;
        wait_tile(6'd5, 6'd2, "tile_5_2_wait");
        @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(d_busy), 64'd0);
        check("midrst_ready", 64'(d_ready), 64'd0);
        check("midrst_render_done", 64'(d_done), 64'd0);
        check("midrst_dispatch_xy", 64'({d_dy, d_dx}), 64'd0);
        check("midrst_current_xy", 64'({d_cy, d_cx}), 64'd0);
        check("midrst_color_zero", 64'(|d_color), 64'd0);
        check("midrst_commits", 64'(d_rd_cnt), 64'd85);
        check("midrst_frame_dones", 64'(d_fd_cnt), 64'd0);
        act = 0;
        repeat (20) begin
            @(negedge clk);
            act += int'(d_busy | d_tile_start | d_done | d_frame_done);
        end
        check("midrst_quiet", 64'(act), 64'd0);

        // Restart from (0,0); frame_start during COLLECT of (3,0) is ignored
        @(posedge clk);
        #1;
        clear_counts();
        c0 = cyc;
        d_start = 1'b1;
        @(posedge clk);
        #1;
        d_start = 1'b0;
        wait_tile(6'd3, 6'd0, "tile_3_0_wait");
        @(posedge clk);
        #1;
        d_start = 1'b1;
        @(posedge clk);
        #1;
        d_start = 1'b0;
        wait_frame_done("frame_b_done_wait");
        check("frame_b_cycles", 64'(cyc - c0), 64'd21600);
        @(posedge clk);
        #1;
        check("frame_b_commits", 64'(d_rd_cnt), 64'd1200);
        check("frame_b_tile_starts", 64'(d_ts_cnt), 64'd1200);
        check("frame_b_frame_dones", 64'(d_fd_cnt), 64'd1);
        act = 0;
        repeat (30) begin
            @(negedge clk);
            act += int'(d_busy | d_tile_start);
        end
        check("frame_b_not_queued", 64'(act), 64'd0);
        d_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
